// File: rtl/map_display_ctrl_pkg.sv
// Shared definitions for the game-board display sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package map_display_ctrl_pkg;

    // Game phase encodings as seen on the phase output. 2'b11 is unused.
    typedef enum logic [1:0] {
        PH_PLACE  = 2'b00,
        PH_ATTACK = 2'b01,
        PH_DONE   = 2'b10
    } phase_t;

    localparam int ROWS     = 7;
    localparam int COLS     = 5;
    localparam int MAP_BITS = ROWS * COLS;

endpackage

// File: rtl/map_display_ctrl_btn.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level debounce, rising-edge pulse.
// Latency: pulse is high DEB_CYCLES + 3 cycles after a clean raw rising edge, for one cycle.
// Backpressure: none; the pulse is fire-and-forget.
//
// Ports: clk, reset (sync, active-high), btn (raw, async), pulse (1-cycle, debounced rise).
module btn_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // cnt holds how many consecutive samples already disagreed with
            // level; the DEB_CYCLES-th disagreeing sample flips the level.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/map_display_ctrl.sv
// Game phase sequencer and row-scanning driver for the 5x7 LED board.
// Latency: ch6->sel_attack 1 cycle; map/select reach col at the next row advance (<= SCAN_DIV cycles).
// Backpressure: none; maps are sampled at row-advance edges, confirm is a pulse.
//
// Ports: clk, reset (sync, active-high), ch6 (view switch), btn_confirm (raw),
//        place_valid, game_over, pos_map/atk_map (bit = row*5+col),
//        sel_attack (registered map select), row_en (one-hot row), col (row pixels), phase.
module map_display_ctrl
    import map_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEB_CYCLES   = 1000,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ch6,
    input  logic                btn_confirm,
    input  logic                place_valid,
    input  logic                game_over,
    input  logic [MAP_BITS-1:0] pos_map,
    input  logic [MAP_BITS-1:0] atk_map,
    output logic                sel_attack,
    output logic [ROWS-1:0]     row_en,
    output logic [COLS-1:0]     col,
    output logic [1:0]          phase
);

    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam int            FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    ROW_LAST = 3'(ROWS - 1);
    localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);

    phase_t          state;
    phase_t          state_nxt;
    logic            sel_nxt;
    logic            confirm;
    logic [DW-1:0]   div_cnt;
    logic [2:0]      row_idx;
    logic [2:0]      row_nxt;
    logic [5:0]      row_base;
    logic [FW-1:0]   frame_cnt;
    logic            blink;
    logic            blink_nxt;
    logic            advance;
    logic            frame_wrap;
    logic [MAP_BITS-1:0] map_cur;
    logic [COLS-1:0] row_bits;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_confirm (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_confirm),
        .pulse (confirm)
    );

    assign phase = state;

    // Phase transitions and map select. game_over is only looked at in
    // ATTACK, so a simultaneous confirm there has no effect and DONE wins.
    always_comb begin
        state_nxt = state;
        case (state)
            PH_PLACE:  if (confirm && place_valid) state_nxt = PH_ATTACK;
            PH_ATTACK: if (game_over) state_nxt = PH_DONE;
            PH_DONE:   state_nxt = PH_DONE;
            default:   state_nxt = PH_PLACE;
        endcase
        sel_nxt = (state_nxt == PH_DONE) | ((state_nxt == PH_ATTACK) & ch6);
    end

    // Scan datapath. The new row's pixels and the blink decision are taken
    // together at the advance edge so a frame is either fully lit or blank.
    always_comb begin
        advance    = (div_cnt == DIV_LAST);
        row_nxt    = (row_idx == ROW_LAST) ? 3'd0 : row_idx + 3'd1;
        frame_wrap = advance && (row_idx == ROW_LAST);
        blink_nxt  = blink;
        if (state != PH_DONE) begin
            blink_nxt = 1'b1;
        end else if (frame_wrap && (frame_cnt == FR_LAST)) begin
            blink_nxt = ~blink;
        end
        map_cur  = sel_attack ? atk_map : pos_map;
        row_base = {3'b000, row_nxt} * 6'd5;
        row_bits = map_cur[row_base +: COLS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PH_PLACE;
            sel_attack <= 1'b0;
            div_cnt    <= '0;
            row_idx    <= 3'd0;
            row_en     <= ROW_ONE;
            col        <= '0;
            frame_cnt  <= '0;
            blink      <= 1'b1;
        end else begin
            state      <= state_nxt;
            sel_attack <= sel_nxt;
            blink      <= blink_nxt;
            if (advance) begin
                div_cnt <= '0;
                row_idx <= row_nxt;
                row_en  <= ROW_ONE << row_nxt;
                col     <= blink_nxt ? row_bits : '0;
                if (frame_wrap) begin
                    frame_cnt <= (frame_cnt == FR_LAST) ? '0 : frame_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule
